// File: rtl/circle_pkg.sv
// Shared enums and default screen geometry for the circle engine.
// Imported by the engine top and its clip sub-module.
package circle_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    STEP,
    DONE
  } state_e;

  typedef enum logic {
    MODE_OUTLINE = 1'b0,
    MODE_FILL    = 1'b1
  } mode_e;

endpackage

// File: rtl/circle_clip.sv
// Combinational visibility test of a signed candidate pixel against
// the screen bounds and an inclusive clip window.
module circle_clip
  import circle_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int PW    = ((XW > YW) ? XW : YW) + 2
)(
  input  logic signed [PW-1:0] px_i,
  input  logic signed [PW-1:0] py_i,
  input  logic [XW-1:0]        clip_xmin_i,
  input  logic [XW-1:0]        clip_xmax_i,
  input  logic [YW-1:0]        clip_ymin_i,
  input  logic [YW-1:0]        clip_ymax_i,
  output logic                 vis_o
);

  localparam logic signed [PW-1:0] W_LIM = PW'(SCR_W);
  localparam logic signed [PW-1:0] H_LIM = PW'(SCR_H);

  logic signed [PW-1:0] xmn, xmx, ymn, ymx;
  logic on_scr, in_win;

  assign xmn = $signed({{(PW-XW){1'b0}}, clip_xmin_i});
  assign xmx = $signed({{(PW-XW){1'b0}}, clip_xmax_i});
  assign ymn = $signed({{(PW-YW){1'b0}}, clip_ymin_i});
  assign ymx = $signed({{(PW-YW){1'b0}}, clip_ymax_i});

  assign on_scr = !px_i[PW-1] && (px_i < W_LIM) &&
                  !py_i[PW-1] && (py_i < H_LIM);

  assign in_win = (px_i >= xmn) && (px_i <= xmx) &&
                  (py_i >= ymn) && (py_i <= ymx);

  assign vis_o = on_scr && in_win;

endmodule

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser: outline or filled disc, clipped,
// streamed one pixel per accepted cycle over a valid/ready port.
module circle_engine
  import circle_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] colour,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  input  logic [XW-1:0] radius,
  input  logic [XW-1:0] clip_xmin,
  input  logic [XW-1:0] clip_xmax,
  input  logic [YW-1:0] clip_ymin,
  input  logic [YW-1:0] clip_ymax,
  input  logic          vga_ready,
  output logic          vga_plot,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          done
);

  localparam int PW = ((XW > YW) ? XW : YW) + 2;
  localparam int KW = XW + 3;

  typedef logic signed [PW-1:0] crd_t;
  typedef logic signed [KW-1:0] crit_t;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] col_q, col_d;
  logic [XW-1:0] cx_q, cx_d, r_q, r_d;
  logic [XW-1:0] xmn_q, xmn_d, xmx_q, xmx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [YW-1:0] ymn_q, ymn_d, ymx_q, ymx_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  crit_t         crit_q, crit_d;
  logic [2:0]    slot_q, slot_d;
  crd_t          sx_q, sx_d;

  crd_t  cx_s, cy_s, x_s, y_s, r_s, xn_s;
  crd_t  px, py, right, nxt_left;
  crit_t xo, xn, yn, inc;
  logic  crit_np, vis, adv, last;

  assign cx_s = $signed({{(PW-XW){1'b0}}, cx_q});
  assign cy_s = $signed({{(PW-YW){1'b0}}, cy_q});
  assign x_s  = $signed({{(PW-XW){1'b0}}, x_q});
  assign y_s  = $signed({{(PW-XW){1'b0}}, y_q});
  assign r_s  = $signed({{(PW-XW){1'b0}}, r_q});

  // Octant candidates come straight from slot; spans walk sx_q.
  always_comb begin
    px = sx_q;
    py = cy_s;
    if (mode_q == MODE_OUTLINE) begin
      unique case (slot_q)
        3'd0: begin px = cx_s + x_s; py = cy_s + y_s; end
        3'd1: begin px = cx_s + y_s; py = cy_s + x_s; end
        3'd2: begin px = cx_s - x_s; py = cy_s + y_s; end
        3'd3: begin px = cx_s - y_s; py = cy_s + x_s; end
        3'd4: begin px = cx_s - x_s; py = cy_s - y_s; end
        3'd5: begin px = cx_s - y_s; py = cy_s - x_s; end
        3'd6: begin px = cx_s + x_s; py = cy_s - y_s; end
        default: begin px = cx_s + y_s; py = cy_s - x_s; end
      endcase
    end else begin
      unique case (slot_q[1:0])
        2'd0:    py = cy_s + y_s;
        2'd1:    py = cy_s - y_s;
        2'd2:    py = cy_s + x_s;
        default: py = cy_s - x_s;
      endcase
    end
  end

  circle_clip #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H),
    .XW    (XW),
    .YW    (YW),
    .PW    (PW)
  ) u_clip (
    .px_i        (px),
    .py_i        (py),
    .clip_xmin_i (xmn_q),
    .clip_xmax_i (xmx_q),
    .clip_ymin_i (ymn_q),
    .clip_ymax_i (ymx_q),
    .vis_o       (vis)
  );

  assign right    = slot_q[1] ? (cx_s + y_s) : (cx_s + x_s);
  assign nxt_left = (slot_q[1:0] == 2'd0) ? (cx_s - x_s)
                                          : (cx_s - y_s);

  assign last = (mode_q == MODE_OUTLINE) ? (slot_q == 3'd7)
              : ((slot_q[1:0] == 2'd3) && (sx_q == right));

  assign adv = (state_q == PLOT) && (!vis || vga_ready);

  // Signed step math so x - 1 at radius 0 ends the loop.
  assign crit_np = (crit_q <= crit_t'(0));
  assign xo   = $signed({3'b000, x_q});
  assign yn   = $signed({3'b000, y_q}) + crit_t'(1);
  assign xn   = crit_np ? xo : (xo - crit_t'(1));
  assign inc  = crit_np ? yn : (yn - xn);
  assign xn_s = $signed({{(PW-XW){1'b0}}, xn[XW-1:0]});

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    xmn_d   = xmn_q;
    xmx_d   = xmx_q;
    ymn_d   = ymn_q;
    ymx_d   = ymx_q;
    x_d     = x_q;
    y_d     = y_q;
    crit_d  = crit_q;
    slot_d  = slot_q;
    sx_d    = sx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          mode_d  = mode_e'(mode);
          col_d   = colour;
          cx_d    = centre_x;
          cy_d    = centre_y;
          r_d     = radius;
          xmn_d   = clip_xmin;
          xmx_d   = clip_xmax;
          ymn_d   = clip_ymin;
          ymx_d   = clip_ymax;
        end
      end
      INIT: begin
        state_d = PLOT;
        x_d     = r_q;
        y_d     = '0;
        crit_d  = crit_t'(1) - $signed({3'b000, r_q});
        slot_d  = '0;
        sx_d    = cx_s - r_s;
      end
      PLOT: begin
        if (adv) begin
          if (last) begin
            state_d = STEP;
          end else if (mode_q == MODE_OUTLINE) begin
            slot_d = slot_q + 3'd1;
          end else if (sx_q == right) begin
            slot_d = slot_q + 3'd1;
            sx_d   = nxt_left;
          end else begin
            sx_d = sx_q + crd_t'(1);
          end
        end
      end
      STEP: begin
        x_d     = xn[XW-1:0];
        y_d     = yn[XW-1:0];
        crit_d  = crit_q + (inc <<< 1) + crit_t'(1);
        slot_d  = '0;
        sx_d    = cx_s - xn_s;
        state_d = (xn >= yn) ? PLOT : DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_OUTLINE;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      xmn_q   <= '0;
      xmx_q   <= '0;
      ymn_q   <= '0;
      ymx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      crit_q  <= '0;
      slot_q  <= '0;
      sx_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      xmn_q   <= xmn_d;
      xmx_q   <= xmx_d;
      ymn_q   <= ymn_d;
      ymx_q   <= ymx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      crit_q  <= crit_d;
      slot_q  <= slot_d;
      sx_q    <= sx_d;
    end
  end

  assign vga_plot   = (state_q == PLOT) && vis;
  assign vga_x      = vga_plot ? px[XW-1:0] : '0;
  assign vga_y      = vga_plot ? py[YW-1:0] : '0;
  assign vga_colour = vga_plot ? col_q : '0;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_circle_engine.sv
// Scoreboard bench for circle_engine: directed draws push expected
// pixels; a negedge monitor pops and compares accepted plots.
module tb_circle_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [7:0] clip_xmin = '0;
  logic [7:0] clip_xmax = '0;
  logic [6:0] clip_ymin = '0;
  logic [6:0] clip_ymax = '0;
  logic       vga_ready = 1'b1;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       done;

  always #5 clk = ~clk;

  circle_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .radius     (radius),
    .clip_xmin  (clip_xmin),
    .clip_xmax  (clip_xmax),
    .clip_ymin  (clip_ymin),
    .clip_ymax  (clip_ymax),
    .vga_ready  (vga_ready),
    .vga_plot   (vga_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  bit corner_chk = 1'b0;
  bit rand_ready = 1'b0;
  logic [7:0] rows_seen = '0;

  // r=3 outline about (80,60), octant order, three steps.
  int o3x[24] = '{83, 80, 77, 80, 77, 80, 83, 80,
                  83, 81, 77, 79, 77, 79, 83, 81,
                  82, 82, 78, 78, 78, 78, 82, 82};
  int o3y[24] = '{60, 63, 60, 63, 60, 57, 60, 57,
                  61, 63, 61, 63, 59, 57, 59, 57,
                  62, 62, 62, 62, 58, 58, 58, 58};
  // r=3 filled about (80,60) clipped to column 80.
  int f3y[12] = '{60, 60, 63, 57, 61, 59, 63, 57,
                  62, 58, 62, 58};

  always @(negedge clk) begin : monitor
    logic [17:0] got;
    logic [17:0] e;
    if (!rst) begin
      got = {vga_x, vga_y, vga_colour};
      if (!vga_plot) begin
        total++;
        if (got != '0) begin
          bad++;
          $display("FAIL idle_zero got=%h want=0", got);
        end
      end else if (vga_ready) begin
        total++;
        if (corner_chk) begin
          if (vga_x > 8'd7 || vga_y > 7'd7) begin
            bad++;
            $display("FAIL corner_bounds got=(%0d,%0d) want<=(7,7)",
                     vga_x, vga_y);
          end else begin
            rows_seen[vga_y[2:0]] = 1'b1;
          end
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_plot got=(%0d,%0d,c%0d) want=none",
                   vga_x, vga_y, vga_colour);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            bad++;
            $display("FAIL pixel got=(%0d,%0d,c%0d) want=(%0d,%0d,c%0d)",
                     got[17:10], got[9:3], got[2:0],
                     e[17:10], e[9:3], e[2:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    exp_q.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic setup(input logic md, input int cx, input int cy,
                       input int r, input int col,
                       input int x0, input int x1,
                       input int y0, input int y1);
    mode      = md;
    centre_x  = 8'(cx);
    centre_y  = 7'(cy);
    radius    = 8'(r);
    colour    = 3'(col);
    clip_xmin = 8'(x0);
    clip_xmax = 8'(x1);
    clip_ymin = 7'(y0);
    clip_ymax = 7'(y1);
  endtask

  // Inputs are scrambled right after capture; the drawing must ignore it.
  task automatic go();
    start = 1'b1;
    tick();
    centre_x  = 8'd200;
    centre_y  = 7'd3;
    radius    = 8'd17;
    mode      = ~mode;
    colour    = ~colour;
    clip_xmin = 8'd0;
    clip_xmax = 8'd255;
    clip_ymin = 7'd0;
    clip_ymax = 7'd127;
  endtask

  task automatic finish_draw(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      if (rand_ready) vga_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check({name, "_done"}, int'(done), 1);
    vga_ready = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check({name, "_done_clr"}, int'(done), 0);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_plot", int'(vga_plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_done", int'(done), 0);

    setup(1'b0, 10, 10, 0, 1, 0, 255, 0, 127);
    repeat (8) push(10, 10, 1);
    go();
    finish_draw("r0_outline");

    setup(1'b1, 10, 10, 0, 2, 0, 255, 0, 127);
    repeat (4) push(10, 10, 2);
    go();
    finish_draw("r0_fill");

    setup(1'b0, 80, 60, 3, 3, 0, 255, 0, 127);
    for (int i = 0; i < 24; i++) push(o3x[i], o3y[i], 3);
    go();
    finish_draw("r3_outline");

    setup(1'b1, 80, 60, 3, 4, 80, 80, 0, 127);
    for (int i = 0; i < 12; i++) push(80, f3y[i], 4);
    go();
    finish_draw("fill_col80");

    setup(1'b0, 80, 60, 3, 6, 80, 255, 0, 127);
    for (int i = 0; i < 24; i++)
      if (o3x[i] >= 80) push(o3x[i], o3y[i], 6);
    rand_ready = 1'b1;
    go();
    finish_draw("half_clip_bp");
    rand_ready = 1'b0;

    setup(1'b1, 2, 2, 5, 7, 0, 255, 0, 127);
    rows_seen = '0;
    corner_chk = 1'b1;
    go();
    finish_draw("corner");
    corner_chk = 1'b0;
    check("corner_rows", int'(rows_seen), 255);

    setup(1'b1, 80, 60, 3, 5, 100, 50, 0, 127);
    go();
    finish_draw("empty_clip");

    setup(1'b0, 80, 60, 3, 5, 0, 255, 0, 127);
    for (int i = 0; i < 24; i++) push(o3x[i], o3y[i], 5);
    vga_ready = 1'b0;
    start = 1'b1;
    for (int n = 0; n < 20 && !vga_plot; n++) tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_plot", int'(vga_plot), 1);
      check("stall_x", int'(vga_x), 83);
      check("stall_y", int'(vga_y), 60);
      tick();
    end
    vga_ready = 1'b1;
    finish_draw("stall");

    setup(1'b0, 80, 60, 3, 2, 0, 255, 0, 127);
    for (int i = 0; i < 24; i++) push(o3x[i], o3y[i], 2);
    start = 1'b1;
    repeat (6) tick();
    vga_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_done", int'(done), 0);
    exp_q.delete();
    start = 1'b0;
    vga_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    setup(1'b0, 80, 60, 3, 1, 0, 255, 0, 127);
    for (int i = 0; i < 24; i++) push(o3x[i], o3y[i], 1);
    go();
    finish_draw("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
